// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: execute-side inputs, memory-side outputs, branch training and statistics.
// The master drives the EX fields and stall; the slave (the stage) drives the MEM fields.
interface ex_mem_stage_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             valid_EX;
    logic [31:0]      aluRes_EX;
    logic [31:0]      storeData_EX;
    logic [4:0]       destReg_EX;
    logic             regWrite_EX;
    logic             memRead_EX;
    logic             memWrite_EX;
    logic             memToReg_EX;
    logic             branch_EX;
    logic             taken_EX;
    logic             predTaken_EX;
    logic [31:0]      pcPlus4_EX;
    logic [31:0]      brTarget_EX;

    logic [31:0]      aluRes_MEM;
    logic [31:0]      storeData_MEM;
    logic [4:0]       destReg_MEM;
    logic             regWrite_MEM;
    logic             memRead_MEM;
    logic             memWrite_MEM;
    logic             memToReg_MEM;
    logic             valid_MEM;
    logic             flush_MEM;
    logic [31:0]      redirectPC;
    logic             bpuUpdate;
    logic [31:0]      bpuPC;
    logic             bpuTaken;
    logic [CNT_W-1:0] brCount;
    logic [CNT_W-1:0] mispCount;

    modport master (
        output stall, valid_EX, aluRes_EX, storeData_EX, destReg_EX, regWrite_EX,
               memRead_EX, memWrite_EX, memToReg_EX, branch_EX, taken_EX,
               predTaken_EX, pcPlus4_EX, brTarget_EX,
        input  aluRes_MEM, storeData_MEM, destReg_MEM, regWrite_MEM, memRead_MEM,
               memWrite_MEM, memToReg_MEM, valid_MEM, flush_MEM, redirectPC,
               bpuUpdate, bpuPC, bpuTaken, brCount, mispCount
    );

    modport slave (
        input  stall, valid_EX, aluRes_EX, storeData_EX, destReg_EX, regWrite_EX,
               memRead_EX, memWrite_EX, memToReg_EX, branch_EX, taken_EX,
               predTaken_EX, pcPlus4_EX, brTarget_EX,
        output aluRes_MEM, storeData_MEM, destReg_MEM, regWrite_MEM, memRead_MEM,
               memWrite_MEM, memToReg_MEM, valid_MEM, flush_MEM, redirectPC,
               bpuUpdate, bpuPC, bpuTaken, brCount, mispCount
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, registered flush/redirect and BPU training.
// Optional saturating branch statistics are enabled by defining BRANCH_STATS_EN.
module ex_mem_stage #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    ex_mem_stage_if.slave  bus
);
    logic live;
    logic misp;

    // An instruction sitting in EX while a flush is out is wrong-path and must become a bubble.
    always_comb begin
        live = bus.valid_EX & ~bus.flush_MEM;
        misp = live & bus.branch_EX & (bus.taken_EX ^ bus.predTaken_EX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.valid_MEM     <= 1'b0;
            bus.aluRes_MEM    <= '0;
            bus.storeData_MEM <= '0;
            bus.destReg_MEM   <= '0;
            bus.regWrite_MEM  <= 1'b0;
            bus.memRead_MEM   <= 1'b0;
            bus.memWrite_MEM  <= 1'b0;
            bus.memToReg_MEM  <= 1'b0;
            bus.flush_MEM     <= 1'b0;
            bus.redirectPC    <= '0;
            bus.bpuUpdate     <= 1'b0;
            bus.bpuPC         <= '0;
            bus.bpuTaken      <= 1'b0;
        end else if (!bus.stall) begin
            bus.valid_MEM     <= live;
            bus.aluRes_MEM    <= bus.aluRes_EX;
            bus.storeData_MEM <= bus.storeData_EX;
            bus.destReg_MEM   <= bus.destReg_EX;
            bus.regWrite_MEM  <= bus.regWrite_EX & live;
            bus.memRead_MEM   <= bus.memRead_EX & live;
            bus.memWrite_MEM  <= bus.memWrite_EX & live;
            bus.memToReg_MEM  <= bus.memToReg_EX & live;
            bus.flush_MEM     <= misp;
            // Redirect is held between mispredicts so it stays stable while a flush is stalled.
            if (misp) begin
                bus.redirectPC <= bus.taken_EX ? bus.brTarget_EX : bus.pcPlus4_EX;
            end
            bus.bpuUpdate     <= live & bus.branch_EX;
            bus.bpuPC         <= bus.pcPlus4_EX - 32'd4;
            bus.bpuTaken      <= bus.taken_EX;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] misp_cnt;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt   <= '0;
            misp_cnt <= '0;
        end else if (!bus.stall) begin
            if (live && bus.branch_EX && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (misp && (misp_cnt != '1)) begin
                misp_cnt <= misp_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.brCount   = br_cnt;
    assign bus.mispCount = misp_cnt;
`else
    assign bus.brCount   = {CNT_W{1'b0}};
    assign bus.mispCount = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push hand-computed expectations,
// a monitor pops one per clock and compares every output.
module tb_ex_mem_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic        stall, valid, branch, taken, pred;
        logic        regWrite, memRead, memWrite, memToReg;
        logic [31:0] alu, sdata, pc4, tgt;
        logic [4:0]  dest;
    } stim_t;

    typedef struct packed {
        logic        valid, regWrite, memRead, memWrite, memToReg;
        logic        flush, bpuUpdate, bpuTaken;
        logic [31:0] alu, sdata, redirect, bpuPC, brCnt, mispCnt;
        logic [4:0]  dest;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];

    ex_mem_stage_if #(.CNT_W(32)) bus ();

    ex_mem_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", tag, field, act, req);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkField(tag, "valid_MEM",     32'(bus.valid_MEM),    32'(e.valid));
        checkField(tag, "aluRes_MEM",    bus.aluRes_MEM,        e.alu);
        checkField(tag, "storeData_MEM", bus.storeData_MEM,     e.sdata);
        checkField(tag, "destReg_MEM",   32'(bus.destReg_MEM),  32'(e.dest));
        checkField(tag, "regWrite_MEM",  32'(bus.regWrite_MEM), 32'(e.regWrite));
        checkField(tag, "memRead_MEM",   32'(bus.memRead_MEM),  32'(e.memRead));
        checkField(tag, "memWrite_MEM",  32'(bus.memWrite_MEM), 32'(e.memWrite));
        checkField(tag, "memToReg_MEM",  32'(bus.memToReg_MEM), 32'(e.memToReg));
        checkField(tag, "flush_MEM",     32'(bus.flush_MEM),    32'(e.flush));
        checkField(tag, "redirectPC",    bus.redirectPC,        e.redirect);
        checkField(tag, "bpuUpdate",     32'(bus.bpuUpdate),    32'(e.bpuUpdate));
        checkField(tag, "bpuPC",         bus.bpuPC,             e.bpuPC);
        checkField(tag, "bpuTaken",      32'(bus.bpuTaken),     32'(e.bpuTaken));
        checkField(tag, "brCount",       bus.brCount,   STATS ? e.brCnt   : 32'd0);
        checkField(tag, "mispCount",     bus.mispCount, STATS ? e.mispCnt : 32'd0);
    endtask

    task automatic driveInputs(input stim_t s);
        bus.stall        = s.stall;
        bus.valid_EX     = s.valid;
        bus.aluRes_EX    = s.alu;
        bus.storeData_EX = s.sdata;
        bus.destReg_EX   = s.dest;
        bus.regWrite_EX  = s.regWrite;
        bus.memRead_EX   = s.memRead;
        bus.memWrite_EX  = s.memWrite;
        bus.memToReg_EX  = s.memToReg;
        bus.branch_EX    = s.branch;
        bus.taken_EX     = s.taken;
        bus.predTaken_EX = s.pred;
        bus.pcPlus4_EX   = s.pc4;
        bus.brTarget_EX  = s.tgt;
    endtask

    task automatic applyStimulus(input string tag, input stim_t s, input exp_t e);
        @(negedge clk);
        driveInputs(s);
        expQ.push_back(e);
        nameQ.push_back(tag);
    endtask

    // Monitor: one expectation per rising edge while any are queued.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        exp_t  e;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        driveInputs('0);
        #2;
        checkOutput("reset", '0);
        @(negedge clk);
        reset = 1'b1;

        s = '0; s.valid = 1; s.alu = 32'h1234; s.regWrite = 1; s.dest = 5;
        e = '0; e.valid = 1; e.alu = 32'h1234; e.regWrite = 1; e.dest = 5; e.bpuPC = 32'hFFFF_FFFC;
        applyStimulus("T1_alu", s, e);

        s = '0; s.valid = 1; s.branch = 1; s.pred = 0; s.taken = 1; s.pc4 = 32'h40; s.tgt = 32'h80; s.alu = 32'hAAAA;
        e = '0; e.valid = 1; e.alu = 32'hAAAA; e.flush = 1; e.redirect = 32'h80; e.bpuUpdate = 1;
        e.bpuPC = 32'h3C; e.bpuTaken = 1; e.brCnt = 1; e.mispCnt = 1;
        applyStimulus("T2_taken_misp", s, e);

        s = '0; s.valid = 1; s.alu = 32'h5555; s.sdata = 32'h77; s.dest = 7; s.regWrite = 1; s.memRead = 1;
        s.memWrite = 1; s.memToReg = 1; s.branch = 1; s.pred = 0; s.taken = 1; s.pc4 = 32'h200; s.tgt = 32'h300;
        e = '0; e.alu = 32'h5555; e.sdata = 32'h77; e.dest = 7; e.redirect = 32'h80; e.bpuPC = 32'h1FC;
        e.bpuTaken = 1; e.brCnt = 1; e.mispCnt = 1;
        applyStimulus("T2_squash", s, e);

        s = '0; s.valid = 1; s.branch = 1; s.pred = 1; s.taken = 0; s.pc4 = 32'h100; s.tgt = 32'h180; s.alu = 32'h10;
        e = '0; e.valid = 1; e.alu = 32'h10; e.flush = 1; e.redirect = 32'h100; e.bpuUpdate = 1;
        e.bpuPC = 32'hFC; e.brCnt = 2; e.mispCnt = 2;
        applyStimulus("T3_nt_misp", s, e);

        s = '0;
        e = '0; e.redirect = 32'h100; e.bpuPC = 32'hFFFF_FFFC; e.brCnt = 2; e.mispCnt = 2;
        applyStimulus("bubble", s, e);

        s = '0; s.valid = 1; s.branch = 1; s.pred = 1; s.taken = 1; s.pc4 = 32'h20; s.tgt = 32'h60; s.alu = 32'h33;
        s.memRead = 1; s.memToReg = 1; s.regWrite = 1; s.dest = 9;
        e = '0; e.valid = 1; e.alu = 32'h33; e.memRead = 1; e.memToReg = 1; e.regWrite = 1; e.dest = 9;
        e.redirect = 32'h100; e.bpuUpdate = 1; e.bpuPC = 32'h1C; e.bpuTaken = 1; e.brCnt = 3; e.mispCnt = 2;
        applyStimulus("T4_correct", s, e);

        s = '0; s.valid = 1; s.taken = 1; s.memWrite = 1; s.alu = 32'h44; s.sdata = 32'hDEAD_BEEF;
        s.pc4 = 32'h24; s.tgt = 32'h999;
        e = '0; e.valid = 1; e.memWrite = 1; e.alu = 32'h44; e.sdata = 32'hDEAD_BEEF; e.redirect = 32'h100;
        e.bpuPC = 32'h20; e.bpuTaken = 1; e.brCnt = 3; e.mispCnt = 2;
        applyStimulus("nonbranch", s, e);

        s = '0; s.branch = 1; s.pred = 1; s.pc4 = 32'h28;
        e = '0; e.redirect = 32'h100; e.bpuPC = 32'h24; e.brCnt = 3; e.mispCnt = 2;
        applyStimulus("invalid_branch", s, e);

        s = '0; s.valid = 1; s.branch = 1; s.taken = 1; s.pc4 = 32'h400; s.tgt = 32'h800; s.alu = 32'h99; s.dest = 3;
        e = '0; e.valid = 1; e.alu = 32'h99; e.dest = 3; e.flush = 1; e.redirect = 32'h800; e.bpuUpdate = 1;
        e.bpuPC = 32'h3FC; e.bpuTaken = 1; e.brCnt = 4; e.mispCnt = 3;
        applyStimulus("T5_flush", s, e);

        for (int i = 0; i < 3; i++) begin
            s = '0; s.stall = 1; s.valid = 1; s.alu = 32'hBAD; s.branch = 1; s.pred = 1; s.pc4 = 32'h500;
            s.tgt = 32'h600; s.regWrite = 1; s.dest = 31;
            applyStimulus("T5_stall", s, e);
        end

        s.stall = 0;
        e = '0; e.alu = 32'hBAD; e.dest = 31; e.redirect = 32'h800; e.bpuPC = 32'h4FC; e.brCnt = 4; e.mispCnt = 3;
        applyStimulus("T5_release", s, e);

        s = '0; s.valid = 1; s.branch = 1; s.pred = 1; s.pc4 = 32'h1000; s.tgt = 32'h2000; s.alu = 32'h1;
        e = '0; e.valid = 1; e.alu = 32'h1; e.flush = 1; e.redirect = 32'h1000; e.bpuUpdate = 1;
        e.bpuPC = 32'hFFC; e.brCnt = 5; e.mispCnt = 4;
        applyStimulus("T6_flush", s, e);

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("T6_async_reset", '0);
        driveInputs('0);
        @(negedge clk);
        reset = 1'b1;

        s = '0; s.valid = 1; s.alu = 32'h77; s.regWrite = 1; s.dest = 2; s.pc4 = 32'h4;
        e = '0; e.valid = 1; e.alu = 32'h77; e.regWrite = 1; e.dest = 2;
        applyStimulus("restart", s, e);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
